// File: rtl/logphy_pkg.sv
// Shared types, default widths and elaboration helpers for the logphy transmit path.
package logphy_pkg;

   localparam int DEF_DATA_W = 128;
   localparam int DEF_LANES  = 4;
   localparam int DEF_LANE_W = 8;
   localparam int DEF_CNT_W  = 16;

   // Serializer control state: IDLE = hold empty, SEND = streaming, DRAIN = enable dropped, finishing
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Number of beats needed to move one word across all lanes
   function automatic int calc_beats(input int data_w, input int lanes, input int lane_w);
      return data_w / (lanes * lane_w);
   endfunction

   // Width of a beat index; never narrower than one bit so BEATS=1 still elaborates
   function automatic int calc_idx_w(input int beats);
      int w;
      w = $clog2(beats);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/logphy_lane_beat_select.sv
// Picks the LANES*LANE_W slice of the held word that belongs to the current beat.
// Kept as its own block so a lane-reversal variant can be dropped in later.
module logphy_lane_beat_select
   import logphy_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SLICE_W = DEF_LANES * DEF_LANE_W,
   parameter int BEATS   = calc_beats(DEF_DATA_W, DEF_LANES, DEF_LANE_W),
   parameter int BEAT_W  = calc_idx_w(BEATS)
)
(
   input  logic [DATA_W-1:0]  i_word,
   input  logic [BEAT_W-1:0]  i_beat,
   output logic [SLICE_W-1:0] o_lane_data
);

   // AND-OR mux over beats: byte b lands on lane b%LANES during beat b/LANES
   always_comb begin
      o_lane_data = '0;
      for (int k = 0; k < BEATS; k++) begin
         o_lane_data = o_lane_data |
                       (i_word[k*SLICE_W +: SLICE_W] & {SLICE_W{i_beat == BEAT_W'(k)}});
      end
   end

endmodule

// File: rtl/logphy_tx_lane_serializer.sv
// Dequeues flit words from the logphy Queue and stripes them across the lanes,
// one beat per PHY handshake. A hold/pend pair keeps back-to-back words bubble-free.
module logphy_tx_lane_serializer
   import logphy_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LANES  = DEF_LANES,
   parameter int LANE_W = DEF_LANE_W,
   parameter int CNT_W  = DEF_CNT_W
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable_i,
   input  logic                    deq_valid_i,
   input  logic [DATA_W-1:0]       data_i,
   output logic                    deq_rdy_o,
   input  logic                    tx_rdy_i,
   output logic                    tx_valid_o,
   output logic [LANES*LANE_W-1:0] lane_data_o,
   output logic                    sof_o,
   output logic                    eof_o,
   output logic                    busy_o,
   output logic [CNT_W-1:0]        word_cnt_o
);

   localparam int SLICE_W = LANES * LANE_W;
   localparam int BEATS   = calc_beats(DATA_W, LANES, LANE_W);
   localparam int BEAT_W  = calc_idx_w(BEATS);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   if ((DATA_W % SLICE_W) != 0) begin : g_bad_width
      $error("DATA_W must be a multiple of LANES*LANE_W");
   end

   logic [DATA_W-1:0]  r_hold;
   logic [DATA_W-1:0]  r_pend;
   logic               r_hold_valid;
   logic               r_pend_valid;
   logic [BEAT_W-1:0]  r_beat;
   logic [CNT_W-1:0]   r_word_cnt;
   state_e             r_state;

   logic               w_deq_rdy;
   logic               w_accept;
   logic               w_beat_fire;
   logic               w_last_fire;
   logic               w_hold_free;
   logic               w_hold_valid_nxt;
   state_e             w_state_nxt;
   logic [SLICE_W-1:0] w_slice;

   // Ready depends only on state and enable; reset forces it low so nothing is taken mid-reset
   assign w_deq_rdy        = enable_i & ~r_pend_valid & ~reset;
   assign w_accept         = deq_valid_i & w_deq_rdy;
   assign w_beat_fire      = r_hold_valid & tx_rdy_i;
   assign w_last_fire      = w_beat_fire & (r_beat == LAST_BEAT);
   assign w_hold_free      = ~r_hold_valid | w_last_fire;
   assign w_hold_valid_nxt = w_hold_free ? (r_pend_valid | w_accept) : 1'b1;

   // Next control state from enable and whether hold will still be occupied
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_hold_valid_nxt) w_state_nxt = ST_SEND;
            else                  w_state_nxt = ST_IDLE;
         end
         ST_SEND: begin
            if (!w_hold_valid_nxt) w_state_nxt = ST_IDLE;
            else if (!enable_i)    w_state_nxt = ST_DRAIN;
            else                   w_state_nxt = ST_SEND;
         end
         ST_DRAIN: begin
            if (!w_hold_valid_nxt) w_state_nxt = ST_IDLE;
            else if (enable_i)     w_state_nxt = ST_SEND;
            else                   w_state_nxt = ST_DRAIN;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Hold/pend buffer and beat index: pend drains into hold first, a fresh word fills the gap
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hold       <= '0;
         r_pend       <= '0;
         r_hold_valid <= 1'b0;
         r_pend_valid <= 1'b0;
         r_beat       <= '0;
      end else if (w_hold_free) begin
         r_hold_valid <= r_pend_valid | w_accept;
         r_beat       <= '0;
         if (r_pend_valid) begin
            r_hold       <= r_pend;
            r_pend_valid <= w_accept;
            if (w_accept) r_pend <= data_i;
         end else if (w_accept) begin
            r_hold <= data_i;
         end
      end else begin
         if (w_beat_fire) r_beat <= r_beat + BEAT_W'(1);
         if (w_accept) begin
            r_pend       <= data_i;
            r_pend_valid <= 1'b1;
         end
      end
   end

   // Completed-word counter and control state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_word_cnt <= '0;
         r_state    <= ST_IDLE;
      end else begin
         if (w_last_fire) r_word_cnt <= r_word_cnt + CNT_W'(1);
         r_state <= w_state_nxt;
      end
   end

   logphy_lane_beat_select #(
      .DATA_W  (DATA_W),
      .SLICE_W (SLICE_W),
      .BEATS   (BEATS),
      .BEAT_W  (BEAT_W)
   ) u_beat_select (
      .i_word      (r_hold),
      .i_beat      (r_beat),
      .o_lane_data (w_slice)
   );

   assign deq_rdy_o   = w_deq_rdy;
   assign tx_valid_o  = r_hold_valid;
   assign lane_data_o = r_hold_valid ? w_slice : '0;
   assign sof_o       = r_hold_valid & (r_beat == '0);
   assign eof_o       = r_hold_valid & (r_beat == LAST_BEAT);
   assign busy_o      = r_hold_valid | r_pend_valid;
   assign word_cnt_o  = r_word_cnt;

endmodule

// File: tb/tb_logphy_tx_lane_serializer.sv
// Scoreboard bench for the lane serializer: stimulus pushes expected beats,
// a monitor pops and compares on every presented beat.
module tb_logphy_tx_lane_serializer;

   typedef struct packed {
      logic [31:0] d;
      logic        sof;
      logic        eof;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable_i;
   logic          deq_valid_i;
   logic [127:0]  data_i;
   logic          deq_rdy_o;
   logic          tx_rdy_i;
   logic          tx_valid_o;
   logic [31:0]   lane_data_o;
   logic          sof_o;
   logic          eof_o;
   logic          busy_o;
   logic [3:0]    word_cnt_o;

   int            n_checks = 0;
   int            n_errors = 0;
   beat_t         sb_q[$];
   logic [127:0]  feed_q[$];
   logic          acc;

   logphy_tx_lane_serializer #(
      .DATA_W (128),
      .LANES  (4),
      .LANE_W (8),
      .CNT_W  (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable_i    (enable_i),
      .deq_valid_i (deq_valid_i),
      .data_i      (data_i),
      .deq_rdy_o   (deq_rdy_o),
      .tx_rdy_i    (tx_rdy_i),
      .tx_valid_o  (tx_valid_o),
      .lane_data_o (lane_data_o),
      .sof_o       (sof_o),
      .eof_o       (eof_o),
      .busy_o      (busy_o),
      .word_cnt_o  (word_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue a word for the feeder and its four expected beats for the scoreboard
   task automatic push_word(input logic [127:0] w);
      beat_t b;
      for (int k = 0; k < 4; k++) begin
         b.d   = w[k*32 +: 32];
         b.sof = (k == 0);
         b.eof = (k == 3);
         sb_q.push_back(b);
      end
      feed_q.push_back(w);
   endtask

   task automatic push_beat(input logic [31:0] d, input logic s, input logic e);
      beat_t b;
      b.d   = d;
      b.sof = s;
      b.eof = e;
      sb_q.push_back(b);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while ((busy_o || deq_valid_i || feed_q.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({"idle_", name}, 64'(n < 200), 64'd1);
      chk({"sb_empty_", name}, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic wait_sof(input string name);
      int n = 0;
      @(negedge clk);
      while (!(tx_valid_o && sof_o) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({"sof_seen_", name}, 64'(n < 50), 64'd1);
   endtask

   // Queue model: offers the head word, pops it when the DUT accepts
   initial begin
      deq_valid_i = 1'b0;
      data_i      = '0;
      forever begin
         @(negedge clk);
         acc = deq_valid_i & deq_rdy_o;
         @(posedge clk);
         #1;
         if (acc) void'(feed_q.pop_front());
         deq_valid_i = (feed_q.size() != 0);
         data_i      = (feed_q.size() != 0) ? feed_q[0] : '0;
      end
   end

   // Monitor: every presented beat must match the scoreboard head; pop on handshake
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!reset && tx_valid_o) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_beat: got %0h expected none", lane_data_o);
            end else begin
               e = sb_q[0];
               chk("beat", 64'({lane_data_o, sof_o, eof_o}), 64'({e.d, e.sof, e.eof}));
               if (tx_rdy_i) void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [12:0]  exp_rdy;
      logic [127:0] w;
      reset    = 1'b1;
      enable_i = 1'b1;
      tx_rdy_i = 1'b1;
      exp_rdy  = 13'b1111000100011;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_valid", 64'(tx_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_cnt", 64'(word_cnt_o), 64'd0);
      chk("rst_deq_rdy", 64'(deq_rdy_o), 64'd0);
      chk("rst_lane", 64'(lane_data_o), 64'd0);
      chk("rst_sof_eof", 64'({sof_o, eof_o}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single word, hand-computed lane beats
      @(negedge clk);
      push_beat(32'h66778899, 1'b1, 1'b0);
      push_beat(32'h22334455, 1'b0, 1'b0);
      push_beat(32'hEEFF0011, 1'b0, 1'b0);
      push_beat(32'hAABBCCDD, 1'b0, 1'b1);
      feed_q.push_back(128'hAABBCCDDEEFF00112233445566778899);
      wait_idle("single");
      chk("single_cnt", 64'(word_cnt_o), 64'd1);
      chk("single_busy", 64'(busy_o), 64'd0);

      // Back-to-back: three words stream with no gap
      push_word(128'h0F0E0D0C0B0A09080706050403020100);
      push_word(128'h1F1E1D1C1B1A19181716151413121110);
      push_word(128'h2F2E2D2C2B2A29282726252423222120);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i < 13) chk("b2b_deq_rdy", 64'(deq_rdy_o), 64'(exp_rdy[i]));
         else        chk("b2b_deq_rdy_end", 64'(deq_rdy_o), 64'd1);
         chk("b2b_tx_valid", 64'(tx_valid_o), 64'((i >= 1) && (i <= 12)));
      end
      wait_idle("b2b");
      chk("b2b_cnt", 64'(word_cnt_o), 64'd4);

      // Backpressure on beat 2
      push_word(128'hAABBCCDDEEFF00112233445566778899);
      wait_sof("bp");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      tx_rdy_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_lane", 64'(lane_data_o), 64'h00000000EEFF0011);
         chk("bp_eof", 64'(eof_o), 64'd0);
      end
      @(posedge clk);
      #1;
      tx_rdy_i = 1'b1;
      @(negedge clk);
      chk("bp_release_lane", 64'(lane_data_o), 64'h00000000EEFF0011);
      @(negedge clk);
      chk("bp_beat3", 64'({lane_data_o, eof_o}), 64'({32'hAABBCCDD, 1'b1}));
      wait_idle("bp");
      chk("bp_cnt", 64'(word_cnt_o), 64'd5);

      // Enable drop during beat 1 with pend full
      push_word(128'hDEADBEEF0123456789ABCDEFCAFEF00D);
      push_word(128'h11111111222222223333333344444444);
      wait_sof("drop");
      @(posedge clk);
      #1;
      enable_i = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("drop_deq_rdy", 64'(deq_rdy_o), 64'd0);
         chk("drop_tx_valid", 64'(tx_valid_o), 64'd1);
      end
      @(negedge clk);
      chk("drop_done", 64'({tx_valid_o, busy_o}), 64'd0);
      chk("drop_cnt", 64'(word_cnt_o), 64'd7);
      @(posedge clk);
      #1;
      enable_i = 1'b1;

      // Reset mid-word on beat 2
      @(negedge clk);
      push_word(128'h55555555666666667777777788888888);
      wait_sof("rst");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      sb_q.delete();
      @(negedge clk);
      chk("mid_rst_tx_valid", 64'(tx_valid_o), 64'd0);
      chk("mid_rst_busy", 64'(busy_o), 64'd0);
      chk("mid_rst_cnt", 64'(word_cnt_o), 64'd0);
      chk("mid_rst_deq_rdy", 64'(deq_rdy_o), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      push_word(128'h99999999AAAAAAAABBBBBBBBCCCCCCCC);
      wait_idle("fresh");
      chk("fresh_cnt", 64'(word_cnt_o), 64'd1);

      // Counter wrap with a 4-bit count: 15, then 0, then 1
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         w = {32'(i + 3), 32'(i + 2), 32'(i + 1), 32'(i)};
         push_word(w);
      end
      wait_idle("wrap15");
      chk("wrap_cnt15", 64'(word_cnt_o), 64'd15);
      push_word(128'h0123456789ABCDEF0011223344556677);
      wait_idle("wrap16");
      chk("wrap_cnt0", 64'(word_cnt_o), 64'd0);
      push_word(128'hFEDCBA98765432108899AABBCCDDEEFF);
      wait_idle("wrap17");
      chk("wrap_cnt1", 64'(word_cnt_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
